pulse_mon: RTL and testbench

Parametrised multi-channel pulse-width monitor for counter carry/strobe outputs. Each of P_CH channels detects a rising edge, checks that the line deasserts after exactly `width_cfg` high cycles, and keeps saturating pass/fail counters, a sticky error flag and the first failing channel. It is synthesisable RTL with no SVA dependency, so it runs in xsim and on hardware alongside the counters it watches. It generalises the single-carry one-cycle check to N channels, a programmable width and an optional minimum-gap check.

---
 rtl/pulse_mon_pkg.sv | 23 ++
 rtl/pulse_mon_if.sv | 31 +++
 rtl/pulse_mon_ch.sv | 141 ++++++++++++++
 rtl/pulse_mon.sv | 66 ++++++
 tb/tb_pulse_mon.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_mon_pkg.sv
// Shared types and helpers for the multi-channel pulse-width monitor.
// Optional minimum-gap checking is enabled with PULSE_MON_GAP_EN.
package pulse_mon_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        WAIT_LOW = 2'd2,
        GAP      = 2'd3
    } pm_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int ch_bit(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int bits);
        logic [63:0] top;
        top = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
        return (v >= top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/pulse_mon_if.sv
// Control and status bundle of pulse_mon; master drives config/lines, slave is the monitor.
interface pulse_mon_if
    import pulse_mon_pkg::*;
#(
    parameter int P_CH        = 4,
    parameter int P_WIDTH_BIT = 4,
    parameter int P_CNT_BIT   = 16
);
    localparam int CH_BIT = ch_bit(P_CH);

    logic                                enable;
    logic                                clr;
    logic [P_WIDTH_BIT-1:0]              width_cfg;
    logic [P_CH-1:0]                     pulse;
    logic [P_CH-1:0][P_CNT_BIT-1:0]      pass_cnt;
    logic [P_CH-1:0][P_CNT_BIT-1:0]      fail_cnt;
    logic [P_CH-1:0]                     err_sticky;
    logic                                first_fail_vld;
    logic [CH_BIT-1:0]                   first_fail_ch;

    modport master (
        output enable, clr, width_cfg, pulse,
        input  pass_cnt, fail_cnt, err_sticky, first_fail_vld, first_fail_ch
    );

    modport slave (
        input  enable, clr, width_cfg, pulse,
        output pass_cnt, fail_cnt, err_sticky, first_fail_vld, first_fail_ch
    );

endinterface

// File: rtl/pulse_mon_ch.sv
// One monitored line: edge detect, width FSM, saturating pass/fail counters, sticky error.
// With PULSE_MON_GAP_EN a minimum low time between pulses is also enforced.
module pulse_mon_ch
    import pulse_mon_pkg::*;
#(
    parameter int P_WIDTH_BIT = 4,
    parameter int P_CNT_BIT   = 16
`ifdef PULSE_MON_GAP_EN
    ,
    parameter int P_MIN_GAP   = 1
`endif
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic                   clr,
    input  logic [P_WIDTH_BIT-1:0] width_cfg,
    input  logic                   pulse,
    output logic [P_CNT_BIT-1:0]   pass_cnt,
    output logic [P_CNT_BIT-1:0]   fail_cnt,
    output logic                   err_sticky,
    output logic                   fail_stb
);
`ifdef PULSE_MON_GAP_EN
    localparam int GAP_BIT = ch_bit(P_MIN_GAP + 1);
    logic [GAP_BIT-1:0] gcnt, gcnt_nxt;
`endif

    pm_state_e              state, state_nxt;
    logic [P_WIDTH_BIT-1:0] wcnt, wcnt_nxt;
    logic [P_WIDTH_BIT-1:0] w_eff;
    logic                   pulse_q;
    logic                   rise;
    logic                   fell;
    logic                   pass_ev;
    logic                   fail_ev;

    assign w_eff = (width_cfg == '0) ? P_WIDTH_BIT'(1) : width_cfg;
    assign rise  = pulse & ~pulse_q;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        fell      = 1'b0;
        pass_ev   = 1'b0;
        fail_ev   = 1'b0;
`ifdef PULSE_MON_GAP_EN
        gcnt_nxt  = gcnt;
`endif
        if (!enable) begin
            state_nxt = IDLE;
            wcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: if (rise) begin
                    state_nxt = HIGH;
                    wcnt_nxt  = P_WIDTH_BIT'(1);
                end
                HIGH: if (pulse) begin
                    if (wcnt == w_eff) begin
                        fail_ev   = 1'b1;
                        state_nxt = WAIT_LOW;
                    end else begin
                        wcnt_nxt = wcnt + P_WIDTH_BIT'(1);
                    end
                end else begin
                    pass_ev = (wcnt == w_eff);
                    fail_ev = (wcnt != w_eff);
                    fell    = 1'b1;
                end
                WAIT_LOW: fell = ~pulse;
`ifdef PULSE_MON_GAP_EN
                // Any high sample inside the gap window is an early pulse.
                GAP: if (pulse) begin
                    fail_ev   = 1'b1;
                    state_nxt = WAIT_LOW;
                end else if (int'(gcnt) + 1 >= P_MIN_GAP) begin
                    state_nxt = IDLE;
                end else begin
                    gcnt_nxt = gcnt + GAP_BIT'(1);
                end
`endif
                default: state_nxt = IDLE;
            endcase
            if (fell) begin
                wcnt_nxt  = '0;
`ifdef PULSE_MON_GAP_EN
                if (P_MIN_GAP > 1) begin
                    state_nxt = GAP;
                    gcnt_nxt  = GAP_BIT'(1);
                end else begin
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
        end
    end

    // pulse_q resets high so a line already high out of reset is not a rise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pulse_q <= 1'b1;
            state   <= IDLE;
            wcnt    <= '0;
`ifdef PULSE_MON_GAP_EN
            gcnt    <= '0;
`endif
        end else begin
            pulse_q <= pulse;
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
`ifdef PULSE_MON_GAP_EN
            gcnt    <= gcnt_nxt;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (pass_ev)
                pass_cnt <= P_CNT_BIT'(sat_inc(64'(pass_cnt), P_CNT_BIT));
            if (fail_ev) begin
                fail_cnt   <= P_CNT_BIT'(sat_inc(64'(fail_cnt), P_CNT_BIT));
                err_sticky <= 1'b1;
            end
        end
    end

    assign fail_stb = fail_ev & ~clr;

endmodule

// File: rtl/pulse_mon.sv
// Multi-channel pulse-width monitor: per-channel checkers plus first-fail capture.
// Define PULSE_MON_GAP_EN to add the minimum-gap check (P_MIN_GAP low cycles).
module pulse_mon
    import pulse_mon_pkg::*;
#(
    parameter int P_CH        = 4,
    parameter int P_WIDTH_BIT = 4,
    parameter int P_CNT_BIT   = 16,
    parameter int P_MIN_GAP   = 1
) (
    input  logic       clk,
    input  logic       resetn,
    pulse_mon_if.slave mon
);
    localparam int CH_BIT = ch_bit(P_CH);

    logic [P_CH-1:0]   fail_stb;
    logic [CH_BIT-1:0] ff_idx;

    if (P_CH < 1 || P_MIN_GAP < 1 || P_CNT_BIT > 64) begin : g_param_chk
        $error("pulse_mon: unsupported parameter set");
    end

    for (genvar g = 0; g < P_CH; g++) begin : g_ch
        pulse_mon_ch #(
            .P_WIDTH_BIT (P_WIDTH_BIT),
            .P_CNT_BIT   (P_CNT_BIT)
`ifdef PULSE_MON_GAP_EN
            ,
            .P_MIN_GAP   (P_MIN_GAP)
`endif
        ) u_ch (
            .clk        (clk),
            .resetn     (resetn),
            .enable     (mon.enable),
            .clr        (mon.clr),
            .width_cfg  (mon.width_cfg),
            .pulse      (mon.pulse[g]),
            .pass_cnt   (mon.pass_cnt[g]),
            .fail_cnt   (mon.fail_cnt[g]),
            .err_sticky (mon.err_sticky[g]),
            .fail_stb   (fail_stb[g])
        );
    end

    // Scan from the top down so the lowest failing index wins.
    always_comb begin
        ff_idx = '0;
        for (int i = P_CH - 1; i >= 0; i--)
            if (fail_stb[i]) ff_idx = CH_BIT'(i);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mon.first_fail_vld <= 1'b0;
            mon.first_fail_ch  <= '0;
        end else if (mon.clr) begin
            mon.first_fail_vld <= 1'b0;
            mon.first_fail_ch  <= '0;
        end else if (!mon.first_fail_vld && (|fail_stb)) begin
            mon.first_fail_vld <= 1'b1;
            mon.first_fail_ch  <= ff_idx;
        end
    end

endmodule

// File: tb/tb_pulse_mon.sv
// Directed and randomized checks of pulse_mon against a run-length reference model.
// Counters are 8 bits wide here so saturation is reachable in a short run.
module tb_pulse_mon;
    import pulse_mon_pkg::*;

    localparam int P_CH        = 4;
    localparam int P_WIDTH_BIT = 4;
    localparam int P_CNT_BIT   = 8;
    localparam int P_MIN_GAP   = 3;
    localparam int CH_BIT      = ch_bit(P_CH);
    localparam int CMAX        = (1 << P_CNT_BIT) - 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    pulse_mon_if #(.P_CH(P_CH), .P_WIDTH_BIT(P_WIDTH_BIT), .P_CNT_BIT(P_CNT_BIT)) mon ();

    pulse_mon #(
        .P_CH(P_CH), .P_WIDTH_BIT(P_WIDTH_BIT), .P_CNT_BIT(P_CNT_BIT), .P_MIN_GAP(P_MIN_GAP)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .mon    (mon)
    );

    // Reference model: each pulse is a run of high samples starting at a 0->1 step.
    int m_pass [P_CH];
    int m_fail [P_CH];
    bit m_err  [P_CH];
    int m_run  [P_CH];
    bit m_live [P_CH];
    bit m_prev [P_CH];
    bit m_ffv;
    int m_ffc;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < P_CH; c++) begin
            m_pass[c] = 0; m_fail[c] = 0; m_err[c] = 0;
            m_run[c] = 0; m_live[c] = 0; m_prev[c] = 1;
        end
        m_ffv = 0;
        m_ffc = 0;
    endtask

    task automatic model_edge(input logic [P_CH-1:0] p);
        int w;
        int first;
        bit pe, fe;
        w = (mon.width_cfg == 0) ? 1 : int'(mon.width_cfg);
        first = -1;
        for (int c = 0; c < P_CH; c++) begin
            pe = 0; fe = 0;
            if (!mon.enable) m_live[c] = 0;
            else if (p[c] && !m_prev[c]) begin m_live[c] = 1; m_run[c] = 1; end
            else if (m_live[c] && p[c]) begin
                m_run[c]++;
                if (m_run[c] > w) begin fe = 1; m_live[c] = 0; end
            end else if (m_live[c] && !p[c]) begin
                if (m_run[c] == w) pe = 1; else fe = 1;
                m_live[c] = 0;
            end
            m_prev[c] = p[c];
            if (!mon.clr) begin
                if (pe && m_pass[c] < CMAX) m_pass[c]++;
                if (fe) begin
                    if (m_fail[c] < CMAX) m_fail[c]++;
                    m_err[c] = 1;
                    if (first < 0) first = c;
                end
            end
        end
        if (mon.clr) begin
            for (int c = 0; c < P_CH; c++) begin m_pass[c] = 0; m_fail[c] = 0; m_err[c] = 0; end
            m_ffv = 0; m_ffc = 0;
        end else if (!m_ffv && first >= 0) begin
            m_ffv = 1; m_ffc = first;
        end
    endtask

    task automatic cycle(input logic [P_CH-1:0] p);
        @(negedge clk);
        mon.pulse = p;
        model_edge(p);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag);
        for (int c = 0; c < P_CH; c++) begin
            chk($sformatf("%s.pass%0d", tag, c), 64'(mon.pass_cnt[c]), 64'(m_pass[c]));
            chk($sformatf("%s.fail%0d", tag, c), 64'(mon.fail_cnt[c]), 64'(m_fail[c]));
            chk($sformatf("%s.err%0d", tag, c), 64'(mon.err_sticky[c]), 64'(m_err[c]));
        end
        chk({tag, ".ffv"}, 64'(mon.first_fail_vld), 64'(m_ffv));
        chk({tag, ".ffc"}, 64'(mon.first_fail_ch), 64'(m_ffc));
    endtask

    task automatic chk_zero(input string tag);
        for (int c = 0; c < P_CH; c++) begin
            chk($sformatf("%s.pass%0d", tag, c), 64'(mon.pass_cnt[c]), 64'd0);
            chk($sformatf("%s.fail%0d", tag, c), 64'(mon.fail_cnt[c]), 64'd0);
        end
        chk({tag, ".err"}, 64'(mon.err_sticky), 64'd0);
        chk({tag, ".ffv"}, 64'(mon.first_fail_vld), 64'd0);
        chk({tag, ".ffc"}, 64'(mon.first_fail_ch), 64'd0);
    endtask

    task automatic set_width(input int w);
        mon.enable = 1'b0;
        mon.width_cfg = P_WIDTH_BIT'(w);
        cycle('0);
        mon.enable = 1'b1;
        cycle('0);
    endtask

    task automatic do_clr();
        mon.clr = 1'b1;
        cycle('0);
        mon.clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold [P_CH];
        logic [P_CH-1:0] lvl;
        mon.enable = 1'b0; mon.clr = 1'b0; mon.width_cfg = '0; mon.pulse = '0;
        model_reset();
        #12;
        chk_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // W = 1, five single-cycle pulses with 3-cycle gaps on ch0
        set_width(1);
        repeat (5) begin
            cycle(4'b0001);
            repeat (3) cycle('0);
        end
        chk("w1.pass0", 64'(mon.pass_cnt[0]), 64'd5);
        chk("w1.fail0", 64'(mon.fail_cnt[0]), 64'd0);
        chk("w1.err", 64'(mon.err_sticky), 64'd0);
        chk_all("w1");

        // W = 3 on ch1: too short, then too long (fails while still high)
        do_clr();
        set_width(3);
        repeat (2) cycle(4'b0010);
        repeat (3) cycle('0);
        chk("w3.short", 64'(mon.fail_cnt[1]), 64'd1);
        repeat (3) cycle(4'b0010);
        chk("w3.long_early", 64'(mon.fail_cnt[1]), 64'd1);
        cycle(4'b0010);
        chk("w3.long_edge", 64'(mon.fail_cnt[1]), 64'd2);
        cycle(4'b0010);
        repeat (3) cycle('0);
        chk("w3.ffv", 64'(mon.first_fail_vld), 64'd1);
        chk("w3.ffc", 64'(mon.first_fail_ch), 64'd1);
        chk_all("w3");

        // ch2 and ch3 fail together, then ch0 fails later
        do_clr();
        set_width(1);
        repeat (2) cycle(4'b1100);
        repeat (3) cycle('0);
        chk("sim.ffc", 64'(mon.first_fail_ch), 64'd2);
        repeat (3) cycle(4'b0001);
        repeat (3) cycle('0);
        chk("late.ffc", 64'(mon.first_fail_ch), 64'd2);
        chk("late.fail0", 64'(mon.fail_cnt[0]), 64'd1);
        chk_all("late");
        do_clr();
        chk_zero("clr");

        // pass counter saturation on ch0
        repeat (CMAX) begin
            cycle(4'b0001);
            repeat (3) cycle('0);
        end
        chk("sat.full", 64'(mon.pass_cnt[0]), 64'(CMAX));
        cycle(4'b0001);
        repeat (3) cycle('0);
        chk("sat.hold", 64'(mon.pass_cnt[0]), 64'(CMAX));
        chk_all("sat");

        // reset in the middle of a pulse on ch0
        set_width(3);
        repeat (2) cycle(4'b0001);
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        #1;
        chk_zero("rst_mid");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) cycle(4'b0001);
        repeat (3) cycle('0);
        chk_zero("rst_after");
        repeat (3) cycle(4'b0001);
        repeat (3) cycle('0);
        chk("rst.repass", 64'(mon.pass_cnt[0]), 64'd1);
        chk_all("rst");

`ifndef PULSE_MON_GAP_EN
        // randomized run-lengths, occasional clr, model compared every 10 cycles
        lvl = '0;
        for (int c = 0; c < P_CH; c++) hold[c] = 1;
        for (int r = 0; r < 6; r++) begin
            set_width(int'($urandom_range(0, 4)));
            for (int k = 0; k < 160; k++) begin
                for (int c = 0; c < P_CH; c++) begin
                    hold[c]--;
                    if (hold[c] <= 0) begin
                        lvl[c] = ~lvl[c];
                        hold[c] = int'($urandom_range(1, 5));
                    end
                end
                mon.clr = ($urandom_range(0, 63) == 0);
                cycle(lvl);
                mon.clr = 1'b0;
                if (k % 10 == 9) chk_all($sformatf("rnd%0d_%0d", r, k));
            end
        end
`else
        // minimum gap: one low cycle is too short, three are enough
        do_clr();
        set_width(1);
        cycle(4'b0001); cycle('0); cycle(4'b0001);
        repeat (4) cycle('0);
        chk("gap1.pass0", 64'(mon.pass_cnt[0]), 64'd1);
        chk("gap1.fail0", 64'(mon.fail_cnt[0]), 64'd1);
        chk("gap1.err0", 64'(mon.err_sticky[0]), 64'd1);
        do_clr();
        cycle(4'b0001); repeat (3) cycle('0);
        cycle(4'b0001); repeat (3) cycle('0);
        chk("gap3.pass0", 64'(mon.pass_cnt[0]), 64'd2);
        chk("gap3.fail0", 64'(mon.fail_cnt[0]), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
